// File: rtl/player_ctrl.sv
// -----------------------------------------------------------------------------
// player_ctrl
//   Owns the player sprite's position and walking animation in the 320x240
//   half-resolution playfield (20x20 sprite). A free-running divider produces
//   a one-cycle move tick; on each tick the held direction keys (priority
//   up > down > left > right) move the sprite by STEP pixels, clamped to the
//   playfield, and advance the walk animation every FRAME_TICKS ticks.
//   Entering an active stage (game state 2, 4 or 6) recentres the player.
//
// Ports
//   clk           in   1  system clock
//   rst_n         in   1  asynchronous reset, active low
//   state         in   4  game state; 2/4/6 are active stages
//   key_up        in   1  up key held (level)
//   key_down      in   1  down key held (level)
//   key_left      in   1  left key held (level)
//   key_right     in   1  right key held (level)
//   blocked       in   1  obstacle ahead, sampled on the tick
//   player_x      out  9  sprite left edge, 0..X_MAX
//   player_y      out  9  sprite top edge, 0..Y_MAX
//   player_state  out  4  sprite frame index dir*3+frame, 0..11
//   moving        out  1  last tick moved or attempted to move
// -----------------------------------------------------------------------------
module player_ctrl #(
    parameter int TICK_DIV    = 1_000_000,
    parameter int STEP        = 1,
    parameter int FRAME_TICKS = 8,
    parameter int X_MAX       = 300,
    parameter int Y_MAX       = 220,
    parameter int START_X     = 150,
    parameter int START_Y     = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] state,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       blocked,
    output logic [8:0] player_x,
    output logic [8:0] player_y,
    output logic [3:0] player_state,
    output logic       moving
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ANIM_LAST  = AW'(FRAME_TICKS - 1);
    localparam logic [8:0]    START_X9   = 9'(START_X);
    localparam logic [8:0]    START_Y9   = 9'(START_Y);
    localparam logic [8:0]    X_MAX9     = 9'(X_MAX);
    localparam logic [8:0]    Y_MAX9     = 9'(Y_MAX);
    localparam logic [8:0]    STEP9      = 9'(STEP);
    localparam logic [9:0]    X_MAX10    = 10'(X_MAX);
    localparam logic [9:0]    Y_MAX10    = 10'(Y_MAX);
    localparam logic [9:0]    STEP10     = 10'(STEP);

    // Direction codes double as the sprite row: player_state = dir*3 + frame.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    logic [TW-1:0] r_tick_cnt;
    logic [3:0]    r_prev_state;
    logic [8:0]    r_x, r_y;
    dir_t          r_dir;
    logic [1:0]    r_frame;
    logic [AW-1:0] r_anim;
    logic          r_moving;
    logic [3:0]    r_pstate;

    logic          w_tick, w_in_stage, w_entry, w_key_act;
    dir_t          w_key_dir, w_dir_nxt;
    logic [8:0]    w_x_nxt, w_y_nxt;
    logic [1:0]    w_frame_nxt;
    logic [AW-1:0] w_anim_nxt;
    logic          w_moving_nxt;
    logic [3:0]    w_pstate_nxt;
    logic [9:0]    w_x_sum, w_y_sum;

    assign w_tick     = (r_tick_cnt == TICK_LAST);
    assign w_in_stage = (state == 4'd2) || (state == 4'd4) || (state == 4'd6);
    assign w_entry    = w_in_stage && (state != r_prev_state);
    // Sums kept one bit wider so the clamp compare sees the true value.
    assign w_x_sum    = {1'b0, r_x} + STEP10;
    assign w_y_sum    = {1'b0, r_y} + STEP10;

    // Move-tick divider and previous-state capture for stage-entry detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt   <= {TW{1'b0}};
            r_prev_state <= 4'd0;
        end else begin
            r_tick_cnt   <= w_tick ? {TW{1'b0}} : r_tick_cnt + TW'(1);
            r_prev_state <= state;
        end
    end

    // Key priority decode: up > down > left > right.
    always_comb begin
        w_key_act = 1'b1;
        w_key_dir = DIR_DOWN;
        if (key_up) begin
            w_key_dir = DIR_UP;
        end else if (key_down) begin
            w_key_dir = DIR_DOWN;
        end else if (key_left) begin
            w_key_dir = DIR_LEFT;
        end else if (key_right) begin
            w_key_dir = DIR_RIGHT;
        end else begin
            w_key_act = 1'b0;
        end
    end

    // Next position, direction, animation and moving flag.
    always_comb begin
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_dir_nxt    = r_dir;
        w_frame_nxt  = r_frame;
        w_anim_nxt   = r_anim;
        w_moving_nxt = r_moving;
        if (w_entry) begin
            w_x_nxt      = START_X9;
            w_y_nxt      = START_Y9;
            w_dir_nxt    = DIR_DOWN;
            w_frame_nxt  = 2'd0;
            w_anim_nxt   = {AW{1'b0}};
            w_moving_nxt = 1'b0;
        end else if (!w_in_stage) begin
            w_moving_nxt = 1'b0;
        end else if (w_tick && !w_key_act) begin
            w_frame_nxt  = 2'd0;
            w_anim_nxt   = {AW{1'b0}};
            w_moving_nxt = 1'b0;
        end else if (w_tick) begin
            w_moving_nxt = 1'b1;
            if (w_key_dir != r_dir) begin
                w_dir_nxt   = w_key_dir;
                w_frame_nxt = 2'd0;
                w_anim_nxt  = {AW{1'b0}};
            end else if (r_anim == ANIM_LAST) begin
                w_anim_nxt  = {AW{1'b0}};
                w_frame_nxt = (r_frame == 2'd2) ? 2'd0 : r_frame + 2'd1;
            end else begin
                w_anim_nxt  = r_anim + AW'(1);
            end
            // Clamp at the playfield edges; animation continues regardless.
            if (!blocked) begin
                case (w_key_dir)
                    DIR_UP:    w_y_nxt = ({1'b0, r_y} < STEP10) ? 9'd0 : r_y - STEP9;
                    DIR_DOWN:  w_y_nxt = (w_y_sum > Y_MAX10) ? Y_MAX9 : w_y_sum[8:0];
                    DIR_LEFT:  w_x_nxt = ({1'b0, r_x} < STEP10) ? 9'd0 : r_x - STEP9;
                    DIR_RIGHT: w_x_nxt = (w_x_sum > X_MAX10) ? X_MAX9 : w_x_sum[8:0];
                    default:   w_x_nxt = r_x;
                endcase
            end else begin
                w_x_nxt = r_x;
            end
        end else begin
            w_moving_nxt = r_moving;
        end
        w_pstate_nxt = ({2'b00, w_dir_nxt} * 4'd3) + {2'b00, w_frame_nxt};
    end

    // Player state registers; outputs come straight from these.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= START_X9;
            r_y      <= START_Y9;
            r_dir    <= DIR_DOWN;
            r_frame  <= 2'd0;
            r_anim   <= {AW{1'b0}};
            r_moving <= 1'b0;
            r_pstate <= 4'd9;
        end else begin
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_dir    <= w_dir_nxt;
            r_frame  <= w_frame_nxt;
            r_anim   <= w_anim_nxt;
            r_moving <= w_moving_nxt;
            r_pstate <= w_pstate_nxt;
        end
    end

    assign player_x     = r_x;
    assign player_y     = r_y;
    assign player_state = r_pstate;
    assign moving       = r_moving;

endmodule

// File: tb/tb_player_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_ctrl
//   Scoreboard bench for player_ctrl. A reference model steps on every clock,
//   pushes the expected outputs into a queue, and a monitor pops and compares
//   on the falling edge. Directed scenarios also check absolute values.
// -----------------------------------------------------------------------------
module tb_player_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int STEP        = 1;
    localparam int FRAME_TICKS = 8;
    localparam int X_MAX       = 300;
    localparam int Y_MAX       = 220;
    localparam int START_X     = 150;
    localparam int START_Y     = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] state = 4'd0;
    logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
    logic       blocked = 1'b0;
    logic [8:0] player_x, player_y;
    logic [3:0] player_state;
    logic       moving;

    player_ctrl #(
        .TICK_DIV(TICK_DIV), .STEP(STEP), .FRAME_TICKS(FRAME_TICKS),
        .X_MAX(X_MAX), .Y_MAX(Y_MAX), .START_X(START_X), .START_Y(START_Y)
    ) dut (
        .clk(clk), .rst_n(rst_n), .state(state),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .blocked(blocked),
        .player_x(player_x), .player_y(player_y),
        .player_state(player_state), .moving(moving)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int ps;
        int mov;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Directions as sprite rows: up 0, right 1, left 2, down 3.
    int m_x, m_y, m_dir, m_frame, m_walk, m_mov, m_cyc, m_prev;

    function automatic exp_t snap();
        exp_t e;
        e.x   = m_x;
        e.y   = m_y;
        e.ps  = m_dir * 3 + m_frame;
        e.mov = m_mov;
        return e;
    endfunction

    task automatic model_reset();
        m_x = START_X; m_y = START_Y; m_dir = 3; m_frame = 0;
        m_walk = 0; m_mov = 0; m_cyc = 0; m_prev = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
                if (clk) exp_q.push_back(snap());
                else exp_q.delete();
            end else begin
                bit tick, active_stage;
                int want;
                tick = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
                m_cyc++;
                active_stage = (state == 2) || (state == 4) || (state == 6);
                want = key_up ? 0 : key_down ? 3 : key_left ? 2 : key_right ? 1 : -1;
                if (active_stage && (int'(state) != m_prev)) begin
                    m_x = START_X; m_y = START_Y; m_dir = 3; m_frame = 0;
                    m_walk = 0; m_mov = 0;
                end else if (!active_stage) begin
                    m_mov = 0;
                end else if (tick) begin
                    if (want < 0) begin
                        m_frame = 0; m_walk = 0; m_mov = 0;
                    end else begin
                        m_mov = 1;
                        if (want != m_dir) begin
                            m_dir = want; m_frame = 0; m_walk = 0;
                        end else begin
                            m_walk++;
                            if (m_walk == FRAME_TICKS) begin
                                m_walk = 0;
                                m_frame = (m_frame + 1) % 3;
                            end
                        end
                        if (!blocked) begin
                            if (want == 0) m_y = (m_y - STEP < 0) ? 0 : m_y - STEP;
                            if (want == 3) m_y = (m_y + STEP > Y_MAX) ? Y_MAX : m_y + STEP;
                            if (want == 2) m_x = (m_x - STEP < 0) ? 0 : m_x - STEP;
                            if (want == 1) m_x = (m_x + STEP > X_MAX) ? X_MAX : m_x + STEP;
                        end
                    end
                end
                m_prev = int'(state);
                exp_q.push_back(snap());
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_x", 32'(player_x), e.x);
                chk("sb_y", 32'(player_y), e.y);
                chk("sb_state", 32'(player_state), e.ps);
                chk("sb_moving", 32'(moving), e.mov);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_keys(input logic u, input logic d, input logic l, input logic r);
        key_up = u; key_down = d; key_left = l; key_right = r;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int st_tab[6];
        st_tab = '{2, 3, 4, 6, 0, 2};

        #1 rst_n = 1'b0;
        cycles(3);
        chk("reset_x", 32'(player_x), 150);
        chk("reset_y", 32'(player_y), 200);
        chk("reset_state", 32'(player_state), 9);
        chk("reset_moving", 32'(moving), 0);
        rst_n = 1'b1;

        // Stage entry.
        state = 4'd2;
        cycles(2);
        chk("entry_x", 32'(player_x), 150);
        chk("entry_state", 32'(player_state), 9);

        // Right for 10 ticks: frame 3 for 8 ticks then 4.
        set_keys(1'b0, 1'b0, 1'b0, 1'b1);
        cycles(10 * TICK_DIV);
        chk("right10_x", 32'(player_x), 160);
        chk("right10_state", 32'(player_state), 4);
        chk("right10_moving", 32'(moving), 1);

        // Clamp at right edge, then at left edge.
        cycles(143 * TICK_DIV);
        chk("clamp_xmax", 32'(player_x), 300);
        set_keys(1'b0, 1'b0, 1'b1, 1'b0);
        cycles(305 * TICK_DIV);
        chk("clamp_x0", 32'(player_x), 0);

        // Up beats left.
        set_keys(1'b1, 1'b0, 1'b1, 1'b0);
        cycles(5 * TICK_DIV);
        chk("upleft_y", 32'(player_y), 195);
        chk("upleft_x", 32'(player_x), 0);
        chk("upleft_state", 32'(player_state), 0);
        set_keys(1'b0, 1'b0, 1'b0, 1'b0);
        cycles(TICK_DIV);
        chk("idle_moving", 32'(moving), 0);
        chk("idle_state", 32'(player_state), 0);

        // Blocked: animation runs, position frozen.
        blocked = 1'b1;
        set_keys(1'b0, 1'b1, 1'b0, 1'b0);
        cycles(9 * TICK_DIV);
        chk("blocked_y", 32'(player_y), 195);
        chk("blocked_state", 32'(player_state), 10);
        blocked = 1'b0;

        // Leave stage, hold, re-enter another stage.
        set_keys(1'b0, 1'b0, 1'b0, 1'b1);
        cycles(10 * TICK_DIV);
        chk("walk_x", 32'(player_x), 10);
        state = 4'd3;
        cycles(5 * TICK_DIV);
        chk("nostage_x", 32'(player_x), 10);
        chk("nostage_moving", 32'(moving), 0);
        state = 4'd4;
        cycles(1);
        chk("reentry_x", 32'(player_x), 150);
        chk("reentry_y", 32'(player_y), 200);
        chk("reentry_state", 32'(player_state), 9);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                set_keys(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 3) == 0) blocked = 1'($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) state = 4'(st_tab[$urandom_range(0, 5)]);
            cycles(1);
        end

        // Asynchronous reset in the middle of movement.
        state = 4'd2;
        set_keys(1'b0, 1'b0, 1'b1, 1'b0);
        blocked = 1'b0;
        cycles(20 * TICK_DIV);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_x", 32'(player_x), 150);
        chk("async_rst_y", 32'(player_y), 200);
        chk("async_rst_state", 32'(player_state), 9);
        chk("async_rst_moving", 32'(moving), 0);
        cycles(2);
        rst_n = 1'b1;
        cycles(10 * TICK_DIV);
        chk("post_rst_x", 32'(player_x), 140);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
